// File: rtl/bus_responder_ram_io.sv
// Target side of the CPU address/data bus: a doubleword RAM plus a bidirectional GPIO block,
// answered with a ready/bus_error pulse after a fixed number of wait states.
module bus_responder_ram_io #(
    parameter int                    DATA_WIDTH     = 64,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    RAM_DEPTH_LOG2 = 8,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE        = 32'hFFFF_0000,
    parameter int                    WAIT_STATES    = 1,
    parameter int                    IO_WIDTH       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  ready,
    output logic                  bus_error,
    inout  wire  [IO_WIDTH-1:0]   IO
);

    localparam int                    RAM_DEPTH   = 1 << RAM_DEPTH_LOG2;
    localparam logic [ADDR_WIDTH:0]   RAM_BYTES   = (ADDR_WIDTH+1)'(RAM_DEPTH) << 3;
    localparam logic [ADDR_WIDTH-1:0] IO_OUT_ADDR = IO_BASE;
    localparam logic [ADDR_WIDTH-1:0] IO_DIR_ADDR = IO_BASE + ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] IO_IN_ADDR  = IO_BASE + ADDR_WIDTH'(16);
    localparam logic [3:0]            WAIT_LOAD   = 4'(WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] TGT_RAM = 2'd0;
    localparam logic [1:0] TGT_OUT = 2'd1;
    localparam logic [1:0] TGT_DIR = 2'd2;
    localparam logic [1:0] TGT_IN  = 2'd3;

    logic [1:0]                state_reg;
    logic [3:0]                cnt_reg;
    logic                      op_write_reg;
    logic                      err_reg;
    logic [1:0]                tgt_reg;
    logic [RAM_DEPTH_LOG2-1:0] idx_reg;
    logic [DATA_WIDTH-1:0]     wdata_reg;

    logic [DATA_WIDTH-1:0]     ram_mem [0:RAM_DEPTH-1];
    logic [DATA_WIDTH-1:0]     ram_rd_reg;
    logic [IO_WIDTH-1:0]       io_rd_reg;
    logic [IO_WIDTH-1:0]       io_out_reg;
    logic [IO_WIDTH-1:0]       io_dir_reg;
    logic [IO_WIDTH-1:0]       io_sync1_reg;
    logic [IO_WIDTH-1:0]       io_sync2_reg;

    logic [1:0]                dec_tgt;
    logic                      dec_err;
    logic                      start;
    logic                      enter_resp;
    logic                      commit;
    logic [1:0]                cur_tgt;
    logic [RAM_DEPTH_LOG2-1:0] cur_idx;
    logic [IO_WIDTH-1:0]       io_in_val;
    logic [DATA_WIDTH-1:0]     rdata;

    // Address decode; an erroneous request never touches any state.
    always_comb begin
        dec_tgt = TGT_RAM;
        dec_err = 1'b0;
        if (address[2:0] != 3'b000) begin
            dec_err = 1'b1;
        end else if ({1'b0, address} < RAM_BYTES) begin
            dec_tgt = TGT_RAM;
        end else if (address == IO_OUT_ADDR) begin
            dec_tgt = TGT_OUT;
        end else if (address == IO_DIR_ADDR) begin
            dec_tgt = TGT_DIR;
        end else if (address == IO_IN_ADDR) begin
            dec_tgt = TGT_IN;
            dec_err = mem_write;
        end else begin
            dec_err = 1'b1;
        end
        if (mem_read && mem_write) begin
            dec_err = 1'b1;
        end
    end

    assign start      = (state_reg == ST_IDLE) && (mem_read || mem_write);
    assign enter_resp = (start && (WAIT_STATES == 0)) || ((state_reg == ST_WAIT) && (cnt_reg == 4'd1));
    assign cur_tgt    = (state_reg == ST_IDLE) ? dec_tgt : tgt_reg;
    assign cur_idx    = (state_reg == ST_IDLE) ? address[RAM_DEPTH_LOG2+2:3] : idx_reg;
    assign commit     = (state_reg == ST_RESP) && op_write_reg && !err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            op_write_reg <= 1'b0;
            err_reg      <= 1'b0;
            tgt_reg      <= TGT_RAM;
            idx_reg      <= '0;
            wdata_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_write_reg <= mem_write;
                        err_reg      <= dec_err;
                        tgt_reg      <= dec_tgt;
                        idx_reg      <= address[RAM_DEPTH_LOG2+2:3];
                        wdata_reg    <= data;
                        cnt_reg      <= WAIT_LOAD;
                        state_reg    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: state_reg <= ST_DONE;
                default: begin
                    // Held strobes keep us here so one request yields one response.
                    if (!mem_read && !mem_write) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Block-RAM style port: registered read on entry to RESP, write as RESP is left.
    always_ff @(posedge clock) begin
        if (enter_resp) begin
            ram_rd_reg <= ram_mem[cur_idx];
        end
        if (commit && !reset && (tgt_reg == TGT_RAM)) begin
            ram_mem[idx_reg] <= wdata_reg;
        end
    end

    // Output-enabled bits read back the driven value rather than the synchronized pin.
    assign io_in_val = (io_sync2_reg & ~io_dir_reg) | (io_out_reg & io_dir_reg);

    always_ff @(posedge clock) begin
        if (reset) begin
            io_out_reg   <= '0;
            io_dir_reg   <= '0;
            io_sync1_reg <= '0;
            io_sync2_reg <= '0;
            io_rd_reg    <= '0;
        end else begin
            io_sync1_reg <= IO;
            io_sync2_reg <= io_sync1_reg;
            if (enter_resp) begin
                case (cur_tgt)
                    TGT_OUT: io_rd_reg <= io_out_reg;
                    TGT_DIR: io_rd_reg <= io_dir_reg;
                    TGT_IN:  io_rd_reg <= io_in_val;
                    default: io_rd_reg <= '0;
                endcase
            end
            if (commit && (tgt_reg == TGT_OUT)) begin
                io_out_reg <= wdata_reg[IO_WIDTH-1:0];
            end
            if (commit && (tgt_reg == TGT_DIR)) begin
                io_dir_reg <= wdata_reg[IO_WIDTH-1:0];
            end
        end
    end

    assign ready     = (state_reg == ST_RESP);
    assign bus_error = ready && err_reg;

    assign rdata = err_reg ? '0
                 : (tgt_reg == TGT_RAM) ? ram_rd_reg
                 : {{(DATA_WIDTH-IO_WIDTH){1'b0}}, io_rd_reg};

    assign data = ((state_reg == ST_RESP) && !op_write_reg) ? rdata : 'z;

    generate
        for (genvar gi = 0; gi < IO_WIDTH; gi++) begin : g_io_pin
            assign IO[gi] = io_dir_reg[gi] ? io_out_reg[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_bus_responder_ram_io.sv
// Bench for bus_responder_ram_io: directed scenarios plus a randomized run against an array model.
// Bus and pins are pulled up, so an undriven net reads as all ones.
module tb_bus_responder_ram_io;

    localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
    localparam logic [63:0] ALL1    = {64{1'b1}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [31:0] addr0 = '0;
    logic        rd0 = 1'b0, wr0 = 1'b0, oe0 = 1'b0;
    logic [63:0] drv0 = '0;
    logic        ready0, err0;
    logic [7:0]  io_hi = '0;
    logic        io_hi_oe = 1'b0;
    tri1 [63:0]  data0;
    tri1 [15:0]  io0;

    assign data0      = oe0 ? drv0 : 'z;
    assign io0[15:8]  = io_hi_oe ? io_hi : 8'hzz;

    logic [31:0] addr_l = '0;
    logic        rd_l = 1'b0, wr_l = 1'b0, oe_l = 1'b0;
    logic [63:0] drv_l = '0;
    logic        ready1, err1, ready2, err2;
    tri1 [63:0]  data1, data2;
    tri1 [15:0]  io1, io2;

    assign data1 = oe_l ? drv_l : 'z;
    assign data2 = oe_l ? drv_l : 'z;

    bus_responder_ram_io #(.WAIT_STATES(1)) dut (
        .clock(clk), .reset(rst), .address(addr0), .data(data0),
        .mem_read(rd0), .mem_write(wr0), .ready(ready0), .bus_error(err0), .IO(io0));

    bus_responder_ram_io #(.WAIT_STATES(0)) dut_ws0 (
        .clock(clk), .reset(rst), .address(addr_l), .data(data1),
        .mem_read(rd_l), .mem_write(wr_l), .ready(ready1), .bus_error(err1), .IO(io1));

    bus_responder_ram_io #(.WAIT_STATES(3)) dut_ws3 (
        .clock(clk), .reset(rst), .address(addr_l), .data(data2),
        .mem_read(rd_l), .mem_write(wr_l), .ready(ready2), .bus_error(err2), .IO(io2));

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] mem_m [0:15];
    logic [15:0] io_out_m = '0;
    logic [15:0] io_dir_m = '0;

    // Results of the last bus_op
    logic [63:0] r_data, r_pre, r_post;
    logic        r_err, r_rdy_after;
    int          r_lat;

    task automatic bus_op(input bit wr, input bit rd, input logic [31:0] a, input logic [63:0] wd);
        bit seen = 1'b0;
        @(negedge clk);
        addr0 = a; rd0 = rd; wr0 = wr; drv0 = wd; oe0 = wr;
        r_lat = 0; r_data = '0; r_err = 1'b0; r_pre = data0;
        while (!seen && r_lat < 20) begin
            @(posedge clk);
            r_lat++;
            @(negedge clk);
            if (ready0) begin
                seen = 1'b1;
                r_data = data0;
                r_err = err0;
            end else begin
                r_pre = data0;
            end
        end
        rd0 = 1'b0; wr0 = 1'b0; oe0 = 1'b0;
        @(negedge clk);
        r_rdy_after = ready0;
        r_post = data0;
        @(negedge clk);
        $display("txn wr=%0b rd=%0b addr=%08h wdata=%016h -> rdata=%016h err=%0b lat=%0d",
                 wr, rd, a, wd, r_data, r_err, r_lat);
    endtask

    task automatic lockstep(input bit wr, input logic [63:0] wd,
                            output int lat1, output int lat2, output int cnt1, output int cnt2,
                            output logic [63:0] d1, output logic [63:0] d2,
                            output logic e1, output logic e2);
        lat1 = -1; lat2 = -1; cnt1 = 0; cnt2 = 0; d1 = '0; d2 = '0; e1 = 1'b0; e2 = 1'b0;
        @(negedge clk);
        addr_l = 32'h0; rd_l = !wr; wr_l = wr; drv_l = wd; oe_l = wr;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready1) begin
                if (lat1 < 0) begin lat1 = c; d1 = data1; e1 = err1; end
                cnt1++;
            end
            if (ready2) begin
                if (lat2 < 0) begin lat2 = c; d2 = data2; e2 = err2; end
                cnt2++;
            end
        end
        rd_l = 1'b0; wr_l = 1'b0; oe_l = 1'b0;
        repeat (2) @(posedge clk);
        $display("txn lockstep wr=%0b: ws0 lat=%0d pulses=%0d, ws3 lat=%0d pulses=%0d",
                 wr, lat1, cnt1, lat2, cnt2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_bus_error got=%b exp=0", err0); end
        checks++; if (data0 !== ALL1) begin errors++; $display("FAIL reset_data_z got=%h exp=%h", data0, ALL1); end
        checks++; if (io0 !== 16'hFFFF) begin errors++; $display("FAIL reset_io_z got=%h exp=ffff", io0); end
        checks++; if ({ready1, ready2} !== 2'b00) begin errors++; $display("FAIL reset_ready_ws got=%b exp=00", {ready1, ready2}); end
    endtask

    task automatic test_ram_rw();
        logic [63:0] v = 64'hDEADBEEF_01234567;
        bus_op(1'b1, 1'b0, 32'h10, v);
        mem_m[2] = v;
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL ram_write_latency got=%0d exp=2", r_lat); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL ram_write_err got=%b exp=0", r_err); end
        bus_op(1'b0, 1'b1, 32'h10, '0);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL ram_read_latency got=%0d exp=2", r_lat); end
        checks++; if (r_data !== v) begin errors++; $display("FAIL ram_read_data got=%h exp=%h", r_data, v); end
        checks++; if (r_pre !== ALL1) begin errors++; $display("FAIL ram_read_z_before got=%h exp=%h", r_pre, ALL1); end
        checks++; if (r_post !== ALL1) begin errors++; $display("FAIL ram_read_z_after got=%h exp=%h", r_post, ALL1); end
        checks++; if (r_rdy_after !== 1'b0) begin errors++; $display("FAIL ram_ready_single got=%b exp=0", r_rdy_after); end
    endtask

    task automatic test_wait_states();
        int l1, l2, c1, c2;
        logic [63:0] d1, d2;
        logic e1, e2;
        logic [63:0] v = 64'h0F1E2D3C_4B5A6978;
        lockstep(1'b1, v, l1, l2, c1, c2, d1, d2, e1, e2);
        checks++; if (l1 !== 1 || l2 !== 4) begin errors++; $display("FAIL ws_write_latency got=%0d/%0d exp=1/4", l1, l2); end
        lockstep(1'b0, '0, l1, l2, c1, c2, d1, d2, e1, e2);
        checks++; if (l1 !== 1) begin errors++; $display("FAIL ws0_read_latency got=%0d exp=1", l1); end
        checks++; if (l2 !== 4) begin errors++; $display("FAIL ws3_read_latency got=%0d exp=4", l2); end
        checks++; if (c1 !== 1 || c2 !== 1) begin errors++; $display("FAIL ws_single_pulse got=%0d/%0d exp=1/1", c1, c2); end
        checks++; if (d1 !== v || d2 !== v) begin errors++; $display("FAIL ws_read_data got=%h/%h exp=%h", d1, d2, v); end
        checks++; if (e1 !== 1'b0 || e2 !== 1'b0) begin errors++; $display("FAIL ws_bus_error got=%b/%b exp=0/0", e1, e2); end
    endtask

    task automatic test_gpio();
        bus_op(1'b1, 1'b0, IO_BASE + 32'h8, 64'hFFFF_FFFF_0000_00FF);
        io_dir_m = 16'h00FF;
        bus_op(1'b1, 1'b0, IO_BASE, 64'h1234_5678_9ABC_A5A5);
        io_out_m = 16'hA5A5;
        checks++; if (io0[7:0] !== 8'hA5) begin errors++; $display("FAIL gpio_drive got=%h exp=a5", io0[7:0]); end
        checks++; if (io0[15:8] !== 8'hFF) begin errors++; $display("FAIL gpio_hi_z got=%h exp=ff", io0[15:8]); end
        io_hi = 8'h3C; io_hi_oe = 1'b1;
        repeat (2) @(posedge clk);
        bus_op(1'b0, 1'b1, IO_BASE + 32'h10, '0);
        checks++; if (r_data !== 64'h3CA5) begin errors++; $display("FAIL gpio_io_in got=%h exp=3ca5", r_data); end
        bus_op(1'b0, 1'b1, IO_BASE + 32'h8, '0);
        checks++; if (r_data !== 64'h00FF) begin errors++; $display("FAIL gpio_dir_read got=%h exp=ff", r_data); end
        bus_op(1'b0, 1'b1, IO_BASE, '0);
        checks++; if (r_data !== 64'hA5A5) begin errors++; $display("FAIL gpio_out_read got=%h exp=a5a5", r_data); end
        io_hi_oe = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] e_addr [4] = '{32'h14, 32'h1000, IO_BASE + 32'h10, 32'h10};
        bit          e_wr   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        bit          e_rd   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            bus_op(e_wr[k], e_rd[k], e_addr[k], 64'h1111_2222_3333_0000);
            checks++; if (r_err !== 1'b1 || r_lat !== 2) begin errors++; $display("FAIL err_case%0d got err=%b lat=%0d exp err=1 lat=2", k, r_err, r_lat); end
            if (!e_wr[k]) begin
                checks++; if (r_data !== 64'h0) begin errors++; $display("FAIL err_read_zero%0d got=%h exp=0", k, r_data); end
            end
        end
        bus_op(1'b0, 1'b1, 32'h10, '0);
        checks++; if (r_data !== mem_m[2]) begin errors++; $display("FAIL err_ram_unchanged got=%h exp=%h", r_data, mem_m[2]); end
        bus_op(1'b0, 1'b1, IO_BASE, '0);
        checks++; if (r_data !== {48'h0, io_out_m}) begin errors++; $display("FAIL err_io_unchanged got=%h exp=%h", r_data, io_out_m); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int lat = 0;
        logic [63:0] d = '0;
        @(negedge clk);
        addr0 = 32'h10; rd0 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready0) begin pulses++; d = data0; end
        end
        $display("txn held read addr=00000010 pulses=%0d rdata=%016h", pulses, d);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_single_pulse got=%0d exp=1", pulses); end
        checks++; if (d !== mem_m[2]) begin errors++; $display("FAIL hold_read_data got=%h exp=%h", d, mem_m[2]); end
        rd0 = 1'b0;
        @(negedge clk);
        rd0 = 1'b1;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready0) break;
        end
        rd0 = 1'b0;
        repeat (2) @(posedge clk);
        $display("txn re-strobe read addr=00000010 lat=%0d", lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL restrobe_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        logic [63:0] v = {$urandom, $urandom};
        bus_op(1'b1, 1'b0, 32'h20, v);
        mem_m[4] = v;
        @(negedge clk);
        addr0 = 32'h20; wr0 = 1'b1; drv0 = 64'h55; oe0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; wr0 = 1'b0; oe0 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ready0) pulses++;
        end
        io_out_m = '0; io_dir_m = '0;
        $display("txn reset during write addr=00000020 pulses=%0d", pulses);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_ready got=%0d exp=0", pulses); end
        checks++; if (data0 !== ALL1) begin errors++; $display("FAIL rst_data_z got=%h exp=%h", data0, ALL1); end
        checks++; if (io0 !== 16'hFFFF) begin errors++; $display("FAIL rst_io_z got=%h exp=ffff", io0); end
        bus_op(1'b0, 1'b1, 32'h20, '0);
        checks++; if (r_data !== v) begin errors++; $display("FAIL rst_write_discarded got=%h exp=%h", r_data, v); end
        bus_op(1'b0, 1'b1, IO_BASE + 32'h8, '0);
        checks++; if (r_data !== 64'h0) begin errors++; $display("FAIL rst_io_dir got=%h exp=0", r_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = {$urandom, $urandom};
            bus_op(1'b1, 1'b0, 32'h200 + 32'(i * 8), mem_m[i]);
            checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL rand_init_err%0d got=%b exp=0", i, r_err); end
        end
        for (int n = 0; n < 40; n++) begin
            int          kind = $urandom_range(0, 5);
            int          i    = $urandom_range(0, 15);
            int          sel  = $urandom_range(0, 2);
            bit          wr   = 1'b0;
            logic [31:0] a;
            logic [63:0] wd   = {$urandom, $urandom};
            logic [63:0] exp_d = '0;
            bit          exp_e = 1'b0;
            case (kind)
                0: begin a = 32'h200 + 32'(i * 8); wr = 1'b1; end
                1: begin a = 32'h200 + 32'(i * 8); exp_d = mem_m[i]; end
                2: begin a = IO_BASE + 32'(sel[0] * 8); wr = 1'b1; end
                3: begin
                    a = IO_BASE + 32'(sel * 8);
                    case (sel)
                        0: exp_d = {48'h0, io_out_m};
                        1: exp_d = {48'h0, io_dir_m};
                        default: exp_d = {48'h0, (io_out_m & io_dir_m) | ~io_dir_m};
                    endcase
                end
                4: begin a = 32'h200 + 32'(i * 8) + 32'($urandom_range(1, 7)); wr = sel[0]; exp_e = 1'b1; end
                default: begin a = (sel == 0) ? IO_BASE + 32'h18 : 32'h800 + 32'(i * 8); wr = sel[1]; exp_e = 1'b1; end
            endcase
            bus_op(wr, !wr, a, wd);
            if (!exp_e && wr) begin
                if (kind == 0) mem_m[i] = wd;
                else if (sel[0]) io_dir_m = wd[15:0];
                else io_out_m = wd[15:0];
            end
            checks++; if (r_err !== exp_e || r_lat !== 2) begin errors++; $display("FAIL rand_resp%0d addr=%h got err=%b lat=%0d exp err=%b lat=2", n, a, r_err, r_lat, exp_e); end
            if (!wr) begin
                checks++; if (r_data !== exp_d) begin errors++; $display("FAIL rand_rdata%0d addr=%h got=%h exp=%h", n, a, r_data, exp_d); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_wait_states();
        test_gpio();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
